// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stage indices, stall patterns, exception codes.
package pipe_ctrl_pkg;

  localparam int unsigned STAGE_NUM = 6;
  localparam int unsigned WORD_W    = 32;

  localparam int unsigned STAGE_PC  = 0;
  localparam int unsigned STAGE_IF  = 1;
  localparam int unsigned STAGE_ID  = 2;
  localparam int unsigned STAGE_EX  = 3;
  localparam int unsigned STAGE_MEM = 4;
  localparam int unsigned STAGE_WB  = 5;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  localparam logic [WORD_W-1:0] EXC_CODE_INT     = 32'h0000_0001;
  localparam logic [WORD_W-1:0] EXC_CODE_SYSCALL = 32'h0000_0008;
  localparam logic [WORD_W-1:0] EXC_CODE_INVALID = 32'h0000_000A;
  localparam logic [WORD_W-1:0] EXC_CODE_OV      = 32'h0000_000C;
  localparam logic [WORD_W-1:0] EXC_CODE_TRAP    = 32'h0000_000D;
  localparam logic [WORD_W-1:0] EXC_CODE_ERET    = 32'h0000_000E;

  localparam logic [WORD_W-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [WORD_W-1:0] ERET_CODE_DEF  = EXC_CODE_ERET;

  typedef logic [STAGE_NUM-1:0] stall_vec_t;

  localparam stall_vec_t STALL_NONE = 6'b000000;
  localparam stall_vec_t STALL_IF   = 6'b000011;
  localparam stall_vec_t STALL_ID   = 6'b000111;
  localparam stall_vec_t STALL_EX   = 6'b001111;
  localparam stall_vec_t STALL_MEM  = 6'b011111;
  localparam stall_vec_t STALL_ALL  = 6'b111111;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic fetch;
  } stall_req_t;

  // ERET returns to EPC; every other exception enters the common vector.
  function automatic logic [WORD_W-1:0] redirect_target(
    input logic [WORD_W-1:0] excepttype,
    input logic [WORD_W-1:0] epc,
    input logic [WORD_W-1:0] eret_code,
    input logic [WORD_W-1:0] vector
  );
    return (excepttype == eret_code) ? epc : vector;
  endfunction

endpackage

// File: rtl/pipe_stall_merge.sv
// Priority encoder of per-stage stall requests into the shared stall vector.
module pipe_stall_merge
  import pipe_ctrl_pkg::*;
(
  input  stall_req_t req_i,
  output stall_vec_t stall_c_o
);

  // The deepest requesting stage freezes itself and everything upstream.
  always_comb begin
    stall_c_o = STALL_NONE;
    if (req_i.mem) begin
      stall_c_o = STALL_MEM;
    end else if (req_i.ex) begin
      stall_c_o = STALL_EX;
    end else if (req_i.id) begin
      stall_c_o = STALL_ID;
    end else if (req_i.fetch) begin
      stall_c_o = STALL_IF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge plus freeze-then-flush exception/ERET redirect.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  state_e             state_q;
  logic [WORD_W-1:0]  target_q;
  logic [WORD_W-1:0]  target_d;
  logic               exc_hit_c;
  stall_req_t         req_c;
  stall_vec_t         merged_stall_c;

  always_comb begin
    req_c.mem   = stallreq_mem_i;
    req_c.ex    = stallreq_ex_i;
    req_c.id    = stallreq_id_i;
    req_c.fetch = stallreq_if_i;
  end

  pipe_stall_merge u_stall_merge (
    .req_i     (req_c),
    .stall_c_o (merged_stall_c)
  );

  assign exc_hit_c = (excepttype_i != ZERO_WORD);
  assign target_d  = redirect_target(excepttype_i, cp0_epc_i, ERET_CODE, EXC_VECTOR);

  // Exceptions freeze the whole pipe; the flush cycle releases it so flush is never paired with stall.
  always_comb begin
    stall_o = STALL_NONE;
    if (resetn) begin
      unique case (state_q)
        ST_RUN:    stall_o = exc_hit_c ? STALL_ALL : merged_stall_c;
        ST_FREEZE: stall_o = STALL_ALL;
        ST_FLUSH:  stall_o = STALL_NONE;
        default:   stall_o = STALL_NONE;
      endcase
    end
  end

  // Target is latched only on detection, so later EPC/excepttype changes are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_RUN;
      target_q <= ZERO_WORD;
      flush_o  <= 1'b0;
      new_pc_o <= ZERO_WORD;
      busy_o   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          flush_o <= 1'b0;
          if (exc_hit_c) begin
            target_q <= target_d;
            state_q  <= ST_FREEZE;
            busy_o   <= 1'b1;
          end
        end
        ST_FREEZE: begin
          state_q  <= ST_FLUSH;
          flush_o  <= 1'b1;
          new_pc_o <= target_q;
          busy_o   <= 1'b1;
        end
        ST_FLUSH: begin
          state_q <= ST_RUN;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_d;
  logic [31:0] perf_flush_cnt_d;

  // Both counters wrap naturally at 32 bits.
  always_comb begin
    perf_stall_cyc_d = perf_stall_cyc_o;
    perf_flush_cnt_d = perf_flush_cnt_o;
    if ((state_q == ST_RUN) && (stall_o != STALL_NONE)) begin
      perf_stall_cyc_d = perf_stall_cyc_o + 32'd1;
    end
    if (state_q == ST_FREEZE) begin
      perf_flush_cnt_d = perf_flush_cnt_o + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cyc_o <= 32'd0;
      perf_flush_cnt_o <= 32'd0;
    end else begin
      perf_stall_cyc_o <= perf_stall_cyc_d;
      perf_flush_cnt_o <= perf_flush_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a phase model.
module tb_pipe_ctrl;

  logic        clk;
  logic        resetn;
  logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  // Model: phase 0 = running, 1 = freeze cycle, 2 = flush cycle.
  int          phase;
  logic [31:0] m_target;

  pipe_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .stallreq_if_i  (stallreq_if_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .excepttype_i   (excepttype_i),
    .cp0_epc_i      (cp0_epc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Deepest requesting stage n stalls stages 0..n-1 as well: (1<<n)-1.
  function automatic logic [5:0] prio_stall();
    int n;
    n = stallreq_mem_i ? 5 : stallreq_ex_i ? 4 : stallreq_id_i ? 3 : stallreq_if_i ? 2 : 0;
    return 6'((1 << n) - 1);
  endfunction

  task automatic model_neg();
    logic [5:0] es;
    @(negedge clk);
    if (!resetn)                  es = 6'd0;
    else if (phase == 1)          es = 6'h3F;
    else if (phase == 2)          es = 6'd0;
    else if (excepttype_i != 0)   es = 6'h3F;
    else                          es = prio_stall();
    chk("stall", 32'(stall_o), 32'(es));
    chk("flush", 32'(flush_o), 32'(phase == 2));
    chk("busy",  32'(busy_o),  32'(phase != 0));
    if (phase == 2) chk("new_pc", new_pc_o, m_target);
  endtask

  task automatic model_pos();
    @(posedge clk);
    if (!resetn) begin
      phase = 0;
    end else begin
      case (phase)
        0: if (excepttype_i != 0) begin
             m_target = (excepttype_i == 32'hE) ? cp0_epc_i : 32'hBFC00380;
             phase = 1;
           end
        1: phase = 2;
        default: phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic cyc();
    model_neg();
    model_pos();
  endtask

  task automatic set_req(input logic m, input logic e, input logic d, input logic f);
    stallreq_mem_i = m; stallreq_ex_i = e; stallreq_id_i = d; stallreq_if_i = f;
  endtask

  int flushes;
  logic [31:0] codes [4];

  initial begin
    pass_cnt = 0; total_cnt = 0; phase = 0; m_target = 0;
    codes[0] = 32'h8; codes[1] = 32'hE; codes[2] = 32'hC; codes[3] = 32'h1;
    resetn = 1'b0; set_req(1, 0, 0, 1);
    excepttype_i = 32'h8; cp0_epc_i = 32'h0;

    // Reset: stall gated even with requests and an exception pending.
    model_neg(); chk("rst_stall_lit", 32'(stall_o), 32'h0); model_pos();
    model_neg(); chk("rst_flush_lit", 32'(flush_o), 32'h0);
    chk("rst_busy_lit", 32'(busy_o), 32'h0); chk("rst_newpc_lit", new_pc_o, 32'h0); model_pos();
    resetn = 1'b1; set_req(0, 0, 0, 0); excepttype_i = 0;

    // Stall priority.
    set_req(0, 0, 1, 0); model_neg(); chk("id_lit", 32'(stall_o), 32'h07); model_pos();
    set_req(0, 1, 1, 0); model_neg(); chk("ex_lit", 32'(stall_o), 32'h0F); model_pos();
    set_req(1, 1, 1, 0); model_neg(); chk("mem_lit", 32'(stall_o), 32'h1F); model_pos();
    set_req(0, 0, 0, 1); model_neg(); chk("if_lit", 32'(stall_o), 32'h03); model_pos();
    set_req(0, 0, 0, 0); model_neg(); chk("none_lit", 32'(stall_o), 32'h00); model_pos();

    // Plain exception: N, N+1 frozen; N+2 flush to vector; N+3 idle.
    excepttype_i = 32'h8;
    model_neg(); chk("exc_n_lit", 32'(stall_o), 32'h3F); model_pos();
    excepttype_i = 0;
    model_neg(); chk("exc_n1_lit", 32'(stall_o), 32'h3F); chk("exc_n1_busy_lit", 32'(busy_o), 32'h1); model_pos();
    model_neg(); chk("exc_n2_flush_lit", 32'(flush_o), 32'h1);
    chk("exc_n2_pc_lit", new_pc_o, 32'hBFC00380); chk("exc_n2_stall_lit", 32'(stall_o), 32'h0); model_pos();
    model_neg(); chk("exc_n3_flush_lit", 32'(flush_o), 32'h0); model_pos();

    // ERET with EPC changed after detection.
    cp0_epc_i = 32'h80001234; excepttype_i = 32'hE; cyc();
    cp0_epc_i = 32'h0; excepttype_i = 0; cyc();
    model_neg(); chk("eret_pc_lit", new_pc_o, 32'h80001234); model_pos();
    cyc();

    // Exception beats stall request; new code during FREEZE ignored; one flush pulse.
    set_req(1, 0, 0, 0); excepttype_i = 32'h8;
    model_neg(); chk("exc_vs_mem_lit", 32'(stall_o), 32'h3F); model_pos();
    set_req(0, 0, 0, 0); excepttype_i = 32'hC; cp0_epc_i = 32'h1111;
    flushes = 0;
    model_neg(); flushes += int'(flush_o); model_pos();
    excepttype_i = 0;
    for (int i = 0; i < 3; i++) begin model_neg(); flushes += int'(flush_o); model_pos(); end
    chk("one_flush_lit", 32'(flushes), 32'd1);

    // Reset during FREEZE: no flush follows.
    excepttype_i = 32'h8; cyc();
    excepttype_i = 0; resetn = 1'b0; cyc();
    resetn = 1'b1;
    model_neg(); chk("rst_frz_flush_lit", 32'(flush_o), 32'h0);
    chk("rst_frz_busy_lit", 32'(busy_o), 32'h0); chk("rst_frz_pc_lit", new_pc_o, 32'h0); model_pos();
    model_neg(); chk("rst_frz_noflush_lit", 32'(flush_o), 32'h0); model_pos();

    // Back-to-back: exception in the first RUN cycle after FLUSH.
    excepttype_i = 32'h8; cyc();
    excepttype_i = 0; cyc(); cyc();
    cp0_epc_i = 32'h0040_0000; excepttype_i = 32'hE;
    model_neg(); chk("b2b_stall_lit", 32'(stall_o), 32'h3F); model_pos();
    excepttype_i = 0; cyc();
    model_neg(); chk("b2b_pc_lit", new_pc_o, 32'h0040_0000); model_pos();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      excepttype_i = ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 3)] : 32'h0;
      cp0_epc_i = $urandom;
      resetn = ($urandom_range(0, 63) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 6-stage MIPS core.
- Merges per-stage stall requests into the shared stall[5:0] vector consumed by every pipeline register, including the ID/EX register.
- Sequences exception and ERET redirection as a two-phase freeze-then-flush operation, producing flush and new_pc.
- Sits beside the datapath; the MEM stage supplies the exception type and CP0 supplies EPC.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- ERET_CODE, 32'h0000000E, excepttype value denoting ERET.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- stallreq_if_i  in  1  fetch not ready (icache miss)
- stallreq_id_i  in  1  load-use hazard
- stallreq_ex_i  in  1  multi-cycle mul/div busy
- stallreq_mem_i  in  1  dcache/bus busy
- excepttype_i  in  32  MEM-stage exception type; 0 = none
- cp0_epc_i  in  32  current EPC from CP0
- stall_o  out  6  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = Stop
- flush_o  out  1  one-cycle flush of all pipeline registers
- new_pc_o  out  32  redirect target; valid when flush_o=1
- busy_o  out  1  high while in FREEZE or FLUSH

Interface rules:
- Reset resetn: synchronous, active-low.
- Clock clk.

Behaviour:
- FSM states: RUN, FREEZE, FLUSH. Reset value is RUN.
- Registered outputs reset to: flush_o=0, new_pc_o=0, busy_o=0.
- stall_o is combinational from state and requests; it is 0 while in reset.

RUN:
- If excepttype_i != 0:
  - stall_o=6'b111111.
  - Latch target: cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
  - Next state FREEZE.
- Otherwise stall_o is set by highest-stage request:
  - mem → 011111
  - ex → 001111
  - id → 000111
  - if → 000011
  - none → 000000

FREEZE (exactly 1 cycle):
- stall_o=111111, busy_o=1.
- Next state FLUSH; flush_o and new_pc_o are registered to assert in FLUSH.

FLUSH (exactly 1 cycle):
- flush_o=1, new_pc_o=latched target, stall_o=000000, busy_o=1.
- Next state RUN; flush_o returns to 0.

Latency and ordering:
- Exception detection to flush_o high is 2 cycles. Total redirect occupancy is 2 cycles.
- flush has priority over stall in every pipeline register; pipe_ctrl never asserts both.

Boundary conditions:
- Exception and any stall request in the same RUN cycle: exception wins.
- New excepttype_i during FREEZE/FLUSH: ignored; the latched target holds.
- Stall requests during FREEZE/FLUSH: ignored.
- Back-to-back: an exception visible in the first RUN cycle after FLUSH starts a new sequence.
- EPC is sampled in the RUN detection cycle only; later changes do not affect new_pc_o.
- resetn low in any state: RUN, all outputs to reset values on the next edge.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cyc_o[31:0] and perf_flush_cnt_o[31:0], both reset 0.
  - perf_stall_cyc_o increments each RUN cycle with stall_o!=0.
  - perf_flush_cnt_o increments once per FLUSH entry.
  - Both wrap 32'hFFFFFFFF→0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Shared define file holds the stage-index constants, Stop/NoStop, ZeroWord, excepttype codes, and the four stall-pattern constants.
- State encoding stays local.
- One natural sub-module: pipe_stall_merge, the combinational priority encoder of the four requests to stall[5:0].
- The FSM, target latch and perf counters stay in pipe_ctrl.

Test Plan:
- Stall priority: reset, then stallreq_id_i=1 → stall_o=000111. Add stallreq_ex_i=1 → 001111. Add stallreq_mem_i=1 → 011111. Release all → 000000.
- Exception: excepttype_i=32'h8 at cycle N → stall_o=111111 at N and N+1; at N+2 flush_o=1, new_pc_o=BFC00380, stall_o=0; at N+3 flush_o=0.
- ERET: cp0_epc_i=32'h80001234, excepttype_i=32'hE → at N+2 new_pc_o=80001234. Change EPC to 0 at N+1 → new_pc_o still 80001234.
- Exception with stallreq_mem_i=1 in the same cycle → 111111, flush_o at N+2. excepttype_i=32'hC during FREEZE → ignored; exactly one flush pulse.
- resetn=0 during FREEZE → next cycle RUN, flush_o=0, busy_o=0, new_pc_o=0; no flush pulse follows.
- PIPE_CTRL_PERF_EN: 5 stall cycles plus 2 exceptions → perf_stall_cyc_o=5, perf_flush_cnt_o=2.
